// File: rtl/periph_bus_bridge.sv
// periph_bus_bridge
// Decodes the data address of lw/sw against a peripheral window. For hits it
// cancels the data-memory access, runs a valid/ready request plus (for reads)
// a response phase on the peripheral bus, and stalls the single-cycle core
// until the transaction completes or the cycle budget runs out. Read data is
// held in rdata for the core's write-back mux.
module periph_bus_bridge #(
    parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
    parameter logic [31:0] PERIPH_MASK = 32'hF000_0000,
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        cancel_data_memory,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        bus_err,
    output logic        p_valid,
    input  logic        p_ready,
    output logic        p_write,
    output logic [31:0] p_addr,
    output logic [31:0] p_wdata,
    input  logic        p_rsp_valid,
    input  logic [31:0] p_rdata
);

    // Counter is wide enough to hold TIMEOUT itself, so it can saturate there.
    localparam int unsigned          CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               p_valid_q;
    logic               p_write_q;
    logic [31:0]        p_addr_q;
    logic [31:0]        p_wdata_q;
    logic [31:0]        rdata_q;
    logic               bus_err_q;
    logic               hit;
    logic               expired;

    // Address decode: only loads and stores can claim the peripheral window.
    assign hit = (is_load | is_store) & ((addr & PERIPH_MASK) == PERIPH_BASE);

    // The control unit gates data-memory write/read-back with this in the same cycle.
    assign cancel_data_memory = hit;

    // Budget counter saturates at TIMEOUT. A handshake accepted in the expiry
    // cycle moves to WAIT with the counter past the limit, so the response
    // then has exactly one WAIT cycle before that phase also gives up.
    assign cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign expired = (cnt_q >= CNT_LAST);

    // Stall decode: hit in IDLE holds the core before the request is launched;
    // DONE releases it so the instruction retires exactly once.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default first, otherwise a missed branch infers a latch.
        stall = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:      stall = hit;
                REQ, WAIT: stall = 1'b1;
                default:   stall = 1'b0;
            endcase
        end
    end

    // Transaction FSM with all bus-facing outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            p_valid_q <= 1'b0;
            p_write_q <= 1'b0;
            p_addr_q  <= '0;
            p_wdata_q <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
            bus_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        p_addr_q  <= {addr[31:2], 2'b00};
                        p_wdata_q <= wdata;
                        p_write_q <= is_store;
                        p_valid_q <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_d;
                    if (p_ready) begin
                        // Handshake wins over expiry in the same cycle.
                        p_valid_q <= 1'b0;
                        state_q   <= p_write_q ? DONE : WAIT;
                    end else if (expired) begin
                        p_valid_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        if (!p_write_q) begin
                            rdata_q <= ERR_DATA;
                        end
                        state_q   <= DONE;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_d;
                    if (p_rsp_valid) begin
                        rdata_q <= p_rdata;
                        state_q <= DONE;
                    end else if (expired) begin
                        bus_err_q <= 1'b1;
                        rdata_q   <= ERR_DATA;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    // hit is deliberately not looked at here: the retiring
                    // instruction is still on the inputs and must not restart.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign p_valid = p_valid_q;
    assign p_write = p_write_q;
    assign p_addr  = p_addr_q;
    assign p_wdata = p_wdata_q;
    assign rdata   = rdata_q;
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Self-checking bench for periph_bus_bridge: a core-side driver issues
// loads/stores, a peripheral model answers with programmed delays, and a
// monitor compares retirements and bus requests against expectations that
// the driver queues from a cycle-budget reference model.
module tb_periph_bus_bridge;

    localparam int          T    = 8;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] MASK = 32'hF000_0000;
    localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
    localparam int          NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_load, is_store;
    logic [31:0] addr, wdata;
    logic        cancel_data_memory, stall, bus_err;
    logic [31:0] rdata;
    logic        p_valid, p_ready, p_write, p_rsp_valid;
    logic [31:0] p_addr, p_wdata, p_rdata;

    periph_bus_bridge #(
        .PERIPH_BASE (BASE),
        .PERIPH_MASK (MASK),
        .TIMEOUT     (T),
        .ERR_DATA    (ERR)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .is_load            (is_load),
        .is_store           (is_store),
        .addr               (addr),
        .wdata              (wdata),
        .cancel_data_memory (cancel_data_memory),
        .stall              (stall),
        .rdata              (rdata),
        .bus_err            (bus_err),
        .p_valid            (p_valid),
        .p_ready            (p_ready),
        .p_write            (p_write),
        .p_addr             (p_addr),
        .p_wdata            (p_wdata),
        .p_rsp_valid        (p_rsp_valid),
        .p_rdata            (p_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        cancel;
        int          stall_cycles;
        int          err_cycles;
        logic [31:0] rdata;
    } ret_t;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          pv_cycles;
    } bus_t;

    ret_t ret_q[$];
    bus_t bus_q[$];
    logic mon_en = 1'b0;

    // Peripheral model programming: ready after bfm_r valid cycles, response
    // bfm_s cycles into the response phase carrying bfm_data.
    int          bfm_r = NEVER;
    int          bfm_s = 0;
    logic [31:0] bfm_data = '0;

    logic [31:0] model_rdata = '0;

    // Reference model: a hit spends `busy` cycles in the bus phases out of a
    // T-cycle budget; a handshake landing on the final budget cycle still gets
    // one cycle for its response.
    task automatic issue(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] wd, input int r, input int s, input logic [31:0] d);
        ret_t ret;
        bus_t bus;
        logic hit;
        int   busy;
        int   limit;
        int   guard;
        logic fin;
        hit = (ld | st) && ((a & MASK) == BASE);
        ret.cancel     = hit;
        ret.err_cycles = 0;
        busy = 0;
        if (hit) begin
            bus.addr      = {a[31:2], 2'b00};
            bus.wr        = st;
            bus.wdata     = wd;
            bus.pv_cycles = (r < T) ? r + 1 : T;
            if (r >= T) begin
                busy = T;
                ret.err_cycles = 1;
                if (!st) model_rdata = ERR;
            end else if (st) begin
                busy = r + 1;
            end else begin
                limit = (r + 1 > T - 1) ? r + 1 : T - 1;
                if (r + 1 + s <= limit) begin
                    busy = r + 2 + s;
                    model_rdata = d;
                end else begin
                    busy = limit + 1;
                    ret.err_cycles = 1;
                    model_rdata = ERR;
                end
            end
            bus_q.push_back(bus);
        end
        ret.stall_cycles = hit ? busy + 1 : 0;
        ret.rdata        = model_rdata;
        ret_q.push_back(ret);

        bfm_r    = r;
        bfm_s    = s;
        bfm_data = d;
        is_load  = ld;
        is_store = st;
        addr     = a;
        wdata    = wd;
        guard    = 0;
        forever begin
            @(negedge clk);
            fin = !stall;
            @(posedge clk);
            #1;
            if (fin) break;
            guard++;
            if (guard > 4 * T + 20) begin
                $display("FAIL issue_timeout: stall still 1 after %0d cycles, expected release", guard);
                $fatal(1, "bench aborted");
            end
        end
    endtask

    task automatic idle(input int n);
        is_load  = 1'b0;
        is_store = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Peripheral model, driven just after each rising edge.
    initial begin
        int   req_k;
        int   wait_k;
        logic in_wait;
        req_k   = 0;
        wait_k  = 0;
        in_wait = 1'b0;
        p_ready = 1'b0;
        p_rsp_valid = 1'b0;
        p_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            p_ready     = 1'b0;
            p_rsp_valid = 1'b0;
            p_rdata     = $urandom;
            if (rst) begin
                req_k   = 0;
                wait_k  = 0;
                in_wait = 1'b0;
            end else if (in_wait) begin
                if (!stall) begin
                    in_wait = 1'b0;
                end else begin
                    if (wait_k == bfm_s) begin
                        p_rsp_valid = 1'b1;
                        p_rdata     = bfm_data;
                        in_wait     = 1'b0;
                    end
                    wait_k++;
                end
            end else if (p_valid) begin
                if (req_k == bfm_r) begin
                    p_ready = 1'b1;
                    in_wait = !p_write;
                    wait_k  = 0;
                    req_k   = 0;
                end else begin
                    req_k++;
                    p_rsp_valid = 1'($urandom_range(0, 1));
                end
            end else begin
                req_k       = 0;
                p_ready     = 1'($urandom_range(0, 1));
                p_rsp_valid = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: compares bus requests while p_valid is up and every retirement.
    initial begin
        int   stall_cnt;
        int   err_cnt;
        int   pv_cnt;
        logic pv_prev;
        ret_t er;
        bus_t eb;
        stall_cnt = 0;
        err_cnt   = 0;
        pv_cnt    = 0;
        pv_prev   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !mon_en) begin
                stall_cnt = 0;
                err_cnt   = 0;
                pv_cnt    = 0;
                pv_prev   = 1'b0;
            end else begin
                if (bus_err) err_cnt++;
                if (p_valid) begin
                    if (bus_q.size() == 0) begin
                        check("spurious_p_valid", 32'(p_valid), 32'd0);
                    end else begin
                        check("p_addr", p_addr, bus_q[0].addr);
                        check("p_write", 32'(p_write), 32'(bus_q[0].wr));
                        if (bus_q[0].wr) check("p_wdata", p_wdata, bus_q[0].wdata);
                    end
                    pv_cnt++;
                end else if (pv_prev) begin
                    if (bus_q.size() != 0) begin
                        eb = bus_q.pop_front();
                        check("p_valid_cycles", 32'(pv_cnt), 32'(eb.pv_cycles));
                    end
                    pv_cnt = 0;
                end
                pv_prev = p_valid;
                if (is_load | is_store) begin
                    if (stall) begin
                        stall_cnt++;
                    end else if (ret_q.size() == 0) begin
                        check("spurious_retire", 32'(ret_q.size()), 32'd1);
                    end else begin
                        er = ret_q.pop_front();
                        check("cancel_data_memory", 32'(cancel_data_memory), 32'(er.cancel));
                        check("stall_cycles", 32'(stall_cnt), 32'(er.stall_cycles));
                        check("bus_err_cycles", 32'(err_cnt), 32'(er.err_cycles));
                        check("rdata", rdata, er.rdata);
                        stall_cnt = 0;
                        err_cnt   = 0;
                    end
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "bench aborted");
    end

    initial begin
        logic [31:0] a;
        logic        st;
        int          r;
        int          s;
        rst      = 1'b1;
        is_load  = 1'b0;
        is_store = 1'b0;
        addr     = '0;
        wdata    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_p_valid", 32'(p_valid), 32'd0);
        check("reset_p_write", 32'(p_write), 32'd0);
        check("reset_p_addr", p_addr, 32'd0);
        check("reset_p_wdata", p_wdata, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_bus_err", 32'(bus_err), 32'd0);
        rst = 1'b0;

        // Reset in the middle of a request that the peripheral never accepts.
        bfm_r    = NEVER;
        is_load  = 1'b1;
        addr     = 32'h4000_0020;
        repeat (2) @(posedge clk);
        #1;
        check("midreq_p_valid", 32'(p_valid), 32'd1);
        check("midreq_stall", 32'(stall), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_stall", 32'(stall), 32'd0);
        check("async_rst_p_valid", 32'(p_valid), 32'd0);
        check("async_rst_p_addr", p_addr, 32'd0);
        @(posedge clk);
        #1;
        is_load = 1'b0;
        rst     = 1'b0;
        mon_en  = 1'b1;
        model_rdata = '0;
        idle(1);

        // Non-hit right after reset release.
        issue(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 0, 32'h1111_1111);
        // Store, peripheral ready immediately.
        issue(1'b0, 1'b1, 32'h4000_0006, 32'h1234_5678, 0, 0, 32'h0);
        // Load, ready after 3 cycles, response 2 cycles after handshake.
        issue(1'b1, 1'b0, 32'h4000_0010, 32'h0, 3, 2, 32'hCAFE_F00D);
        // Load outside the window.
        issue(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 0, 32'h2222_2222);
        // Load with p_ready stuck low: timeout.
        issue(1'b1, 1'b0, 32'h4000_0200, 32'h0, NEVER, 0, 32'h3333_3333);
        // Handshake on the expiry cycle wins, response right after.
        issue(1'b1, 1'b0, 32'h4000_0300, 32'h0, T - 1, 0, 32'h0BAD_F00D);
        // Store timeout leaves rdata untouched.
        issue(1'b0, 1'b1, 32'h4ABC_DEF1, 32'h5555_AAAA, NEVER, 0, 32'h0);
        // Load timing out in the response phase.
        issue(1'b1, 1'b0, 32'h4000_0404, 32'h0, 1, T, 32'h4444_4444);
        // Non-memory instruction cycles.
        idle(2);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[31:28] = 4'h4;
            st = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, T + 1);
            s  = $urandom_range(0, T);
            if (r == T - 1) s = 0;
            issue(!st, st, a, $urandom, r, s, $urandom);
        end
        idle(4);
        check("ret_queue_drained", 32'(ret_q.size()), 32'd0);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/periph_bus_bridge.md
Name: periph_bus_bridge

Overview:
- Sits downstream of the core control unit, beside the data memory.
- Decodes the ALU-computed data address of lw/sw. For the peripheral window it asserts cancel_data_memory, which suppresses data-memory write and read-back.
- Runs a valid/ready request and response transaction on the peripheral bus, stalling the single-cycle core until the transaction completes or times out.
- Returns read data for the result mux.

Parameters:
PERIPH_BASE, 32'h4000_0000, base address of peripheral window
PERIPH_MASK, 32'hF000_0000, address bits compared against PERIPH_BASE
TIMEOUT, 255, max cycles spent in REQ+WAIT before abort (must be >=1)
ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
is_load  input  1  current instruction opcode is 7'b0000011
is_store  input  1  current instruction opcode is 7'b0100011
addr  input  32  data address (ALU result)
wdata  input  32  store data (rs2)
cancel_data_memory  output  1  access targets peripheral window (combinational)
stall  output  1  hold PC and register-file write this cycle
rdata  output  32  peripheral read data, valid in DONE cycle
bus_err  output  1  one-cycle pulse on timeout abort
p_valid  output  1  peripheral request valid
p_ready  input  1  peripheral accepts request
p_write  output  1  1 = write, 0 = read
p_addr  output  32  word address, bits [1:0] forced 0
p_wdata  output  32  write data
p_rsp_valid  input  1  read response valid
p_rdata  input  32  read response data

Behaviour:
- hit = (is_load|is_store) & ((addr & PERIPH_MASK) == PERIPH_BASE).
- cancel_data_memory = hit, combinational, in every state. The control unit uses it in the same cycle.
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- Reset values: stall=0, p_valid=0, p_write=0, p_addr=0, p_wdata=0, rdata=0, bus_err=0, timeout counter=0.
- stall = hit in IDLE (combinational), 1 in REQ and WAIT, 0 in DONE.
- IDLE, hit=1:
  - register p_addr={addr[31:2],2'b00}, p_wdata=wdata, p_write=is_store;
  - clear counter;
  - next state REQ.
- IDLE, hit=0: stay in IDLE; outputs idle.
- REQ:
  - p_valid=1; p_addr, p_wdata, p_write held stable until handshake.
  - p_valid & p_ready, write: next state DONE.
  - p_valid & p_ready, read: next state WAIT.
  - p_valid deasserts the cycle after the handshake.
- WAIT: on p_rsp_valid, rdata<=p_rdata and next state DONE. p_rsp_valid is ignored in all other states.
- Timeout:
  - counter increments each cycle in REQ or WAIT; it is sized to hold TIMEOUT.
  - When counter==TIMEOUT-1 and the state's exit condition is not met in that cycle: next state DONE, bus_err=1 for exactly one cycle (the DONE cycle), rdata<=ERR_DATA for a read (rdata unchanged for a write), p_valid drops.
  - A handshake or response arriving in the same cycle as expiry wins; no error.
- DONE:
  - stall=0, so the instruction retires: a load writes back rdata, a store completes.
  - Next state is IDLE unconditionally. hit is not re-evaluated in DONE, so the same instruction does not restart.
- rdata holds its last value until the next capture.
- Reset asserted mid-transaction: immediate return to IDLE with reset values. A pending peripheral transaction is abandoned.
- Latency:
  - write with p_ready high at REQ: stalls 2 cycles (IDLE, REQ), retires in cycle 3.
  - read: 2 cycles + response delay.
- Non-hit accesses never stall and never touch the peripheral bus.

Test Plan:
- Reset mid-REQ with p_ready=0 -> asynchronously stall=0, p_valid=0, state IDLE; after release, a non-hit instruction runs with stall=0.
- sw to 32'h4000_0006, wdata=32'h1234_5678, p_ready=1 -> cancel_data_memory=1; stall=1 for 2 cycles; p_valid=1 for one cycle with p_addr=32'h4000_0004, p_write=1, p_wdata=32'h1234_5678; DONE with stall=0 and bus_err=0.
- lw from 32'h4000_0010, p_ready delayed 3 cycles, p_rsp_valid 2 cycles after handshake with p_rdata=32'hCAFE_F00D -> p_addr stable throughout REQ; rdata=32'hCAFE_F00D in DONE; stall deasserts in the DONE cycle only.
- lw from 32'h0000_0100 (outside window) -> cancel_data_memory=0, stall=0, p_valid never asserted.
- TIMEOUT=4, lw to peripheral, p_ready stuck 0 -> p_valid high 4 cycles; then DONE with rdata=32'hDEAD_BEEF, bus_err pulsed 1 cycle, back to IDLE.
- TIMEOUT=4, p_ready first asserted on the 4th REQ cycle (expiry cycle) -> handshake accepted, bus_err=0, proceeds to WAIT with counter continuing.
